// File: rtl/ascon_seq_pkg.sv
// Shared types and widths for the ASCON stream sequencer.
package ascon_seq_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 64;
    localparam int TAG_W   = 128;

    // Main message sequencing FSM
    typedef enum logic [3:0] {
        IDLE,
        START,
        KICK,
        COLLECT_AD,
        ISSUE_AD,
        COLLECT_PT,
        ISSUE_PT,
        WAIT_END,
        DRAIN
    } seq_state_t;

    // Which buffer currently owns the host output port
    typedef enum logic [1:0] {
        SER_EMPTY,
        SER_CIPHER,
        SER_TAG
    } ser_state_t;

endpackage

// File: rtl/ascon_out_serializer.sv
// Captures ciphertext blocks and the final tag from the core and streams them
// to the host as 32-bit words; cipher words always win over tag words.
module ascon_out_serializer
    import ascon_seq_pkg::*;
(
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic [BLOCK_W-1:0] cipher_i,
    input  logic               cipher_valid_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               tag_valid_i,
    input  logic               clr_err_i,
    output logic [WORD_W-1:0]  m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               m_tag_o,
    output logic               m_last_o,
    output logic               empty_o,
    output logic               err_overflow_o
);

    logic [BLOCK_W-1:0] cbuf;
    logic [TAG_W-1:0]   tbuf;
    logic [1:0]         c_left;   // cipher words still to send (2..0)
    logic [2:0]         t_left;   // tag words still to send (4..0)
    logic [1:0]         c_rem;    // cipher words left after this cycle's pop
    logic               pop_c;
    logic               pop_t;
    ser_state_t         sel;

    // Pick the source of the current output word
    always_comb begin
        sel = SER_EMPTY;
        if (c_left != 2'd0)
            sel = SER_CIPHER;
        else if (t_left != 3'd0)
            sel = SER_TAG;
    end

    // Word mux: MSW first for both buffers, last flag on the final tag word
    always_comb begin
        m_data_o = '0;
        m_tag_o  = 1'b0;
        m_last_o = 1'b0;
        case (sel)
            SER_CIPHER: m_data_o = (c_left == 2'd2) ? cbuf[63:32] : cbuf[31:0];
            SER_TAG: begin
                m_tag_o  = 1'b1;
                m_last_o = (t_left == 3'd1);
                case (t_left)
                    3'd4:    m_data_o = tbuf[127:96];
                    3'd3:    m_data_o = tbuf[95:64];
                    3'd2:    m_data_o = tbuf[63:32];
                    default: m_data_o = tbuf[31:0];
                endcase
            end
            default: ;
        endcase
    end

    assign m_valid_o = (sel != SER_EMPTY);
    assign empty_o   = (sel == SER_EMPTY);
    assign pop_c     = m_ready_i && (sel == SER_CIPHER);
    assign pop_t     = m_ready_i && (sel == SER_TAG);
    // A word accepted this very cycle no longer counts as undrained
    assign c_rem     = c_left - {1'b0, pop_c};

    // Buffer capture, word countdown and sticky overflow detect
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cbuf           <= '0;
            tbuf           <= '0;
            c_left         <= 2'd0;
            t_left         <= 3'd0;
            err_overflow_o <= 1'b0;
        end else begin
            if (cipher_valid_i) begin
                cbuf   <= cipher_i;
                c_left <= 2'd2;
            end else begin
                c_left <= c_rem;
            end

            if (tag_valid_i) begin
                tbuf   <= tag_i;
                t_left <= 3'd4;
            end else if (pop_t) begin
                t_left <= t_left - 3'd1;
            end

            if (clr_err_i)
                err_overflow_o <= 1'b0;
            else if (cipher_valid_i && (c_rem != 2'd0))
                err_overflow_o <= 1'b1;
        end
    end

endmodule

// File: rtl/ascon_stream_sequencer.sv
// Host-side sequencer for the ASCON-128 core: packs host words into AD/PT
// blocks, walks the core handshake, and returns cipher/tag words to the host.
module ascon_stream_sequencer
    import ascon_seq_pkg::*;
#(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               cmd_start_i,
    input  logic [WORD_W-1:0]  s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic               core_start_o,
    input  logic               core_req_i,
    output logic [BLOCK_W-1:0] core_data_o,
    output logic               core_data_valid_o,
    input  logic [BLOCK_W-1:0] core_cipher_i,
    input  logic               core_cipher_valid_i,
    input  logic [TAG_W-1:0]   core_tag_i,
    input  logic               core_end_i,
    output logic [WORD_W-1:0]  m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               m_tag_o,
    output logic               m_last_o,
    output logic               busy_o,
    output logic               err_overflow_o
);

    localparam logic [3:0] AD_LAST = 4'(NB_AD_BLOCKS - 1);
    localparam logic [3:0] PT_LAST = 4'(NB_PT_BLOCKS - 1);

    seq_state_t         state;
    logic [3:0]         ad_cnt;
    logic [3:0]         pt_cnt;
    logic               wsel;       // 0: next word is the block MSW
    logic [BLOCK_W-1:0] blk;
    logic               ser_empty;
    logic               start_acc;

    assign start_acc   = cmd_start_i && (state == IDLE);
    assign core_data_o = blk;

    // Main FSM: packer, block counters and registered handshake outputs
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state             <= IDLE;
            ad_cnt            <= 4'd0;
            pt_cnt            <= 4'd0;
            wsel              <= 1'b0;
            blk               <= '0;
            core_start_o      <= 1'b0;
            core_data_valid_o <= 1'b0;
            s_ready_o         <= 1'b0;
            busy_o            <= 1'b0;
        end else begin
            core_start_o <= 1'b0;
            case (state)
                IDLE: if (cmd_start_i) begin
                    ad_cnt       <= 4'd0;
                    pt_cnt       <= 4'd0;
                    wsel         <= 1'b0;
                    core_start_o <= 1'b1;
                    busy_o       <= 1'b1;
                    state        <= START;
                end
                START: begin
                    // init confirmation: a zero block offered for one cycle
                    blk               <= '0;
                    core_data_valid_o <= 1'b1;
                    state             <= KICK;
                end
                KICK: begin
                    core_data_valid_o <= 1'b0;
                    s_ready_o         <= 1'b1;
                    state             <= COLLECT_AD;
                end
                COLLECT_AD, COLLECT_PT: if (s_valid_i) begin
                    if (!wsel) begin
                        blk[BLOCK_W-1:WORD_W] <= s_data_i;
                        wsel                  <= 1'b1;
                    end else begin
                        blk[WORD_W-1:0]   <= s_data_i;
                        wsel              <= 1'b0;
                        s_ready_o         <= 1'b0;
                        core_data_valid_o <= 1'b1;
                        state             <= (state == COLLECT_AD) ? ISSUE_AD : ISSUE_PT;
                    end
                end
                ISSUE_AD: if (core_req_i) begin
                    ad_cnt            <= ad_cnt + 4'd1;
                    core_data_valid_o <= 1'b0;
                    s_ready_o         <= 1'b1;
                    state             <= (ad_cnt == AD_LAST) ? COLLECT_PT : COLLECT_AD;
                end
                ISSUE_PT: if (core_req_i) begin
                    pt_cnt            <= pt_cnt + 4'd1;
                    core_data_valid_o <= 1'b0;
                    if (pt_cnt == PT_LAST) begin
                        state <= WAIT_END;
                    end else begin
                        s_ready_o <= 1'b1;
                        state     <= COLLECT_PT;
                    end
                end
                WAIT_END: if (core_end_i) state <= DRAIN;
                DRAIN: if (ser_empty) begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ascon_out_serializer u_ser (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .cipher_i       (core_cipher_i),
        .cipher_valid_i (core_cipher_valid_i),
        .tag_i          (core_tag_i),
        .tag_valid_i    (core_end_i),
        .clr_err_i      (start_acc),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_tag_o        (m_tag_o),
        .m_last_o       (m_last_o),
        .empty_o        (ser_empty),
        .err_overflow_o (err_overflow_o)
    );

endmodule

// File: doc/ascon_stream_sequencer.md
Name: ascon_stream_sequencer

Overview:
- Host-side sequencer that feeds the ASCON-128 core.
- Accepts 32-bit host words, assembles 64-bit associated-data (AD) and plaintext (PT) blocks, and drives the core's start/data handshake in protocol order.
- Captures ciphertext blocks and the final 128-bit tag and serializes them back to the host as 32-bit words.
- Sits between the host bus adapter and the core FSM/datapath.

Parameters:
- NB_AD_BLOCKS, 1, number of 64-bit AD blocks per message (1..15).
- NB_PT_BLOCKS, 4, number of 64-bit PT blocks per message (1..15); last PT block is consumed by the core's finalisation phase.

Ports:
- clock_i  in  1  system clock.
- resetb_i  in  1  asynchronous, active-low reset.
- cmd_start_i  in  1  one-cycle request to process one message; honoured only in IDLE.
- s_data_i  in  32  host input word; MSW of each 64-bit block first.
- s_valid_i  in  1  host word valid.
- s_ready_o  out  1  sequencer accepts word; transfer when s_valid_i & s_ready_o.
- core_start_o  out  1  start pulse to core.
- core_req_i  in  1  core is waiting for a block (level).
- core_data_o  out  64  block to core; stable while core_data_valid_o high.
- core_data_valid_o  out  1  block offered; transfer when core_data_valid_o & core_req_i.
- core_cipher_i  in  64  ciphertext block.
- core_cipher_valid_i  in  1  one-cycle ciphertext strobe.
- core_tag_i  in  128  final tag.
- core_end_i  in  1  one-cycle end-of-message strobe; tag valid same cycle.
- m_data_o  out  32  output word.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  host accepts output word.
- m_tag_o  out  1  current output word is a tag word.
- m_last_o  out  1  last tag word of the message.
- busy_o  out  1  high in every state except IDLE.
- err_overflow_o  out  1  sticky; cleared by an accepted cmd_start_i.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is asynchronous and active-low, and all flops reset on it.
  - Reset values: all outputs 0; both FSMs return to IDLE; counters and buffers cleared.
  - Reset mid-message aborts the message with no drain.
- Main FSM:
  - IDLE: on cmd_start_i, clear block counters and err_overflow_o, then go to START.
  - START: core_start_o=1 for exactly one cycle, then go to KICK.
  - KICK: core_data_valid_o=1 with core_data_o=0 for exactly one cycle, independent of core_req_i. This is the init confirmation the core requires on the cycle after start. Then go to COLLECT_AD.
  - COLLECT_AD / COLLECT_PT:
    - s_ready_o=1.
    - First accepted word loads core_data_o[63:32]; second loads [31:0].
    - After the second word, go to ISSUE_AD / ISSUE_PT (s_ready_o=0).
  - ISSUE_x: core_data_valid_o=1 until core_req_i, i.e. transfer in the same cycle if core_req_i is already high. On transfer:
    - increment ad_cnt / pt_cnt (4-bit);
    - if more blocks of that kind remain, return to the matching COLLECT state;
    - else AD goes to COLLECT_PT, and PT goes to WAIT_END.
  - WAIT_END: on core_end_i go to DRAIN.
  - DRAIN: wait until the output serializer is empty, then go to IDLE.
  - busy_o = (state != IDLE).
  - cmd_start_i outside IDLE is ignored.
- Output serializer:
  - Cipher buffer: on core_cipher_valid_i, capture 64 bits and present 2 words, MSW first, m_tag_o=0.
  - Tag buffer: on core_end_i, capture 128 bits and present 4 words, [127:96] first, m_tag_o=1. m_last_o=1 on the 4th word only.
  - Cipher words always drain before tag words.
  - m_data_o/m_valid_o are held while m_valid_o & !m_ready_i.
  - Zero-bubble: a new word is presented the cycle after each accept.
  - Overflow: core_cipher_valid_i while the cipher buffer still holds an undrained word sets err_overflow_o. The new block overwrites the buffer and its word index restarts at 0.
  - Same-cycle core_cipher_valid_i and core_end_i: both captured; cipher words drain first.
- Counts:
  - Exactly NB_PT_BLOCKS ciphertext strobes are expected per message.
  - Extra strobes in IDLE are captured and emitted; they do not set the error.

Decomposition:
- Package ascon_seq_pkg holds:
  - main-FSM state enum (IDLE, START, KICK, COLLECT_AD, ISSUE_AD, COLLECT_PT, ISSUE_PT, WAIT_END, DRAIN);
  - serializer state enum;
  - localparams WORD_W=32, BLOCK_W=64, TAG_W=128.
- Sub-module ascon_out_serializer contains both capture buffers, word indices, the valid/ready output and overflow detect.
- Top level contains the main FSM, the input packer and the block counters.

Test Plan:
- Nominal, 1 AD + 4 PT:
  - Stimulus: words 0x01234567,0x89ABCDEF for AD, then PT words; core model holds core_req_i=1.
  - Response: core_start_o pulse, KICK pulse on the next cycle, then core_data_o=0x0123456789ABCDEF on the first real transfer. Exactly 5 data transfers after KICK.
- Output order:
  - Stimulus: core returns cipher 0xDEADBEEFCAFEF00D and tag 0x00112233_44556677_8899AABB_CCDDEEFF.
  - Response: words DEADBEEF, CAFEF00D (m_tag_o=0), then 00112233..CCDDEEFF (m_tag_o=1), with m_last_o only on CCDDEEFF.
- Backpressure:
  - Stimulus: core_req_i low 7 cycles in ISSUE_PT; m_ready_i toggles 1/0.
  - Response: core_data_o stable, s_ready_o=0 throughout; no output word duplicated or lost.
- Overflow:
  - Stimulus: m_ready_i=0 with two cipher strobes 3 cycles apart.
  - Response: err_overflow_o=1 and stays set; the next accepted cmd_start_i clears it.
- Reset mid-message:
  - Stimulus: resetb_i low during COLLECT_PT after the first word.
  - Response: all outputs 0 immediately; after release, a fresh cmd_start_i runs a full nominal message correctly.
- Ignored start:
  - Stimulus: cmd_start_i while busy_o=1.
  - Response: no core_start_o pulse; counters unaffected.
